// File: rtl/sar_conv_sequencer_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
// Word width, accumulator sizing and FSM state encodings.
package sar_conv_sequencer_pkg;

  localparam int BIT_ADC = 8;
  localparam int ACC_W   = BIT_ADC + 3;
  localparam int CNT_W   = 4;

  localparam logic [1:0] AVG_LOG2_MAX = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic [1:0] clamp_avg(
    input logic [1:0] l2
  );
    return (l2 > AVG_LOG2_MAX) ? AVG_LOG2_MAX : l2;
  endfunction

  function automatic logic [CNT_W-1:0] avg_count(
    input logic [1:0] l2
  );
    return CNT_W'(1) << l2;
  endfunction

endpackage

// File: rtl/sar_bit_deserializer.sv
// Turns the SAR DIGITAL_OUT stream into words, one bit per
// COMP_CLK falling edge, MSB first.
module sar_bit_deserializer
  import sar_conv_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               comp_clk,
  input  logic               dout,
  output logic               bit_event,
  output logic [BIT_ADC-1:0] word,
  output logic               word_done
);

  logic             comp_q;
  logic [CNT_W-1:0] bit_cnt;

  assign bit_event = en & comp_q & ~comp_clk;
  assign word_done = (bit_cnt == CNT_W'(BIT_ADC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_q  <= 1'b0;
      bit_cnt <= '0;
      word    <= '0;
    end else begin
      comp_q <= comp_clk;
      if (clr) begin
        bit_cnt <= '0;
        word    <= '0;
      end else if (bit_event) begin
        word    <= {word[BIT_ADC-2:0], dout};
        // a bit landing on the done cycle starts the next word
        bit_cnt <= word_done ? CNT_W'(1)
                             : bit_cnt + CNT_W'(1);
      end else if (word_done) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sar_conv_sequencer.sv
// SAR conversion controller: sequencing, averaging, watchdog
// and a single-entry valid/ready result register.
module sar_conv_sequencer
  import sar_conv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 31
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [1:0]         avg_log2,
  input  logic               clr_err,
  input  logic               sar_digital_out,
  input  logic               sar_comp_clk,
  output logic               sar_xrst,
  output logic [BIT_ADC-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state, state_d;
  logic               cont_q;
  logic [1:0]         avg_q;
  logic [ACC_W-1:0]   acc, acc_d, acc_sum;
  logic [CNT_W-1:0]   smp, smp_d, smp_inc;
  logic [WD_W-1:0]    wdog, wdog_d;
  logic               issue, to_set;
  logic [BIT_ADC-1:0] issue_val;
  logic               bit_event, word_done;
  logic [BIT_ADC-1:0] word;
  logic               xfer, ovr_set;

  sar_bit_deserializer u_deser (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clr       (state == IDLE),
    .en        (state == CONV),
    .comp_clk  (sar_comp_clk),
    .dout      (sar_digital_out),
    .bit_event (bit_event),
    .word      (word),
    .word_done (word_done)
  );

  assign sar_xrst = (state == CONV);
  assign busy     = (state == CONV);
  assign xfer     = result_valid & result_ready;
  assign ovr_set  = issue & result_valid & ~xfer;

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    smp_d     = smp;
    wdog_d    = wdog;
    issue     = 1'b0;
    issue_val = '0;
    to_set    = 1'b0;
    acc_sum   = acc + ACC_W'(word);
    smp_inc   = smp + CNT_W'(1);
    unique case (state)
      IDLE: begin
        acc_d  = '0;
        smp_d  = '0;
        wdog_d = '0;
        if (start) state_d = CONV;
      end
      CONV: begin
        wdog_d = bit_event ? '0 : wdog + WD_W'(1);
        if (word_done) begin
          acc_d = acc_sum;
          smp_d = smp_inc;
        end
        // stop beats a timeout, which beats a completing block
        if (stop) begin
          state_d = IDLE;
        end else if (!bit_event &&
                     wdog == WD_W'(TIMEOUT_CYC - 1)) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end else if (word_done &&
                     smp_inc == avg_count(avg_q)) begin
          issue     = 1'b1;
          issue_val = BIT_ADC'(acc_sum >> avg_q);
          acc_d     = '0;
          smp_d     = '0;
          if (!cont_q) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      cont_q <= 1'b0;
      avg_q  <= '0;
      acc    <= '0;
      smp    <= '0;
      wdog   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      smp   <= smp_d;
      wdog  <= wdog_d;
      if (state == IDLE && start) begin
        cont_q <= continuous;
        avg_q  <= clamp_avg(avg_log2);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (issue && (!result_valid || xfer)) begin
      result       <= issue_val;
      result_valid <= 1'b1;
    end else if (xfer) begin
      result_valid <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (to_set)       timeout <= 1'b1;
      else if (clr_err) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural
// SAR stream model (4-cycle COMP_CLK period, MSB first).
module tb_sar_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] avg_log2 = 2'd0;
  logic       clr_err = 1'b0;
  logic       dout;
  logic       comp;
  logic       sar_xrst;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int n_chk = 0;
  int n_pass = 0;

  sar_conv_sequencer dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start           (start),
    .stop            (stop),
    .continuous      (continuous),
    .avg_log2        (avg_log2),
    .clr_err         (clr_err),
    .sar_digital_out (dout),
    .sar_comp_clk    (comp),
    .sar_xrst        (sar_xrst),
    .result          (result),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .busy            (busy),
    .overrun         (overrun),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  logic [7:0] code_tab [16];
  logic [3:0] cidx;
  int         ph, bi;
  bit         stall = 1'b0;

  always @(negedge clk) begin
    if (!sar_xrst) begin
      ph = 0; bi = 7; cidx = 4'd0;
      comp = 1'b0; dout = 1'b0;
    end else begin
      comp = (ph < 2) && !stall;
      dout = code_tab[cidx][bi];
      ph++;
      if (ph == 4) begin
        ph = 0;
        if (bi == 0) begin
          bi = 7; cidx = cidx + 4'd1;
        end else begin
          bi--;
        end
      end
    end
  end

  int         cyc = 0;
  int         n_xfer = 0;
  int         xfer_cyc = 0;
  int         prev_xfer_cyc = 0;
  logic [7:0] xfer_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid && result_ready) begin
      n_xfer        <= n_xfer + 1;
      prev_xfer_cyc <= xfer_cyc;
      xfer_cyc      <= cyc;
      xfer_data     <= result;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output int waited);
    waited = 0;
    while (!result_valid && waited < lim) begin
      tick(); waited++;
    end
  endtask

  task automatic fill(input logic [7:0] c);
    for (int i = 0; i < 16; i++) code_tab[i] = c;
  endtask

  int w, k, nx;

  initial begin
    fill(8'h00);
    #12;
    chk("rst_xrst", sar_xrst, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick(); tick();

    pulse_stop();
    chk("idle_stop_busy", busy, 0);

    // single conversion
    fill(8'hA5);
    pulse_start();
    chk("single_xrst", sar_xrst, 1);
    chk("single_busy", busy, 1);
    wait_valid(300, w);
    chk("single_seen", result_valid, 1);
    chk("single_result", result, 8'hA5);
    chk("single_done_xrst", sar_xrst, 0);
    chk("single_done_busy", busy, 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("single_drop", result_valid, 0);

    // averaging of four words: 47 >> 2 = 11
    fill(8'd14);
    code_tab[0] = 8'd10;
    code_tab[1] = 8'd11;
    code_tab[2] = 8'd12;
    avg_log2 = 2'd2;
    pulse_start();
    avg_log2 = 2'd0;
    wait_valid(400, w);
    chk("avg_seen", result_valid, 1);
    chk("avg_not_early", w > 100, 1);
    chk("avg_result", result, 8'd11);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // continuous with stop mid-word
    fill(8'h3C);
    continuous = 1'b1;
    result_ready = 1'b1;
    nx = n_xfer;
    pulse_start();
    continuous = 1'b0;
    k = 0;
    while (n_xfer < nx + 3 && k < 400) begin
      tick(); k++;
    end
    chk("cont_three", n_xfer - nx, 3);
    chk("cont_data", xfer_data, 8'h3C);
    chk("cont_spacing", xfer_cyc - prev_xfer_cyc, 32);
    repeat (10) tick();
    pulse_stop();
    chk("cont_stop_busy", busy, 0);
    chk("cont_stop_xrst", sar_xrst, 0);
    nx = n_xfer;
    repeat (100) tick();
    chk("cont_no_more", n_xfer - nx, 0);
    result_ready = 1'b0;

    // overrun
    fill(8'h33);
    code_tab[0] = 8'h11;
    code_tab[1] = 8'h22;
    continuous = 1'b1;
    pulse_start();
    continuous = 1'b0;
    wait_valid(300, w);
    chk("ovr_first", result, 8'h11);
    chk("ovr_not_yet", overrun, 0);
    k = 0;
    while (!overrun && k < 100) begin
      tick(); k++;
    end
    chk("ovr_set", overrun, 1);
    chk("ovr_kept", result, 8'h11);
    pulse_stop();
    pulse_clr();
    chk("ovr_clr", overrun, 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("ovr_drain", result_valid, 0);

    // watchdog timeout
    stall = 1'b1;
    pulse_start();
    k = 0;
    while (!timeout && k < 60) begin
      tick(); k++;
    end
    chk("to_cycles", k, 31);
    chk("to_xrst", sar_xrst, 0);
    chk("to_busy", busy, 0);
    chk("to_no_result", result_valid, 0);
    pulse_clr();
    chk("to_clr", timeout, 0);
    stall = 1'b0;

    // reset mid-word with a held result
    fill(8'h5A);
    pulse_start();
    wait_valid(300, w);
    chk("rm_held", result, 8'h5A);
    pulse_start();
    repeat (18) tick();
    rst = 1'b1;
    #1;
    chk("rm_xrst", sar_xrst, 0);
    chk("rm_busy", busy, 0);
    chk("rm_valid", result_valid, 0);
    chk("rm_result", result, 0);
    tick();
    rst = 1'b0;
    fill(8'hC3);
    tick();
    pulse_start();
    wait_valid(300, w);
    chk("rm_after", result, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
